// File: rtl/uart_frame_ctrl_pkg.sv
// Shared definitions for the UART configuration-frame controller.
package uart_frame_ctrl_pkg;

  // Frame parser states: wait for HEAD, then collect ADDR, DATA, SUM.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    GET_SUM  = 2'd3
  } state_t;

  localparam logic [7:0] HEAD_BYTE_DEF = 8'hA5;
  localparam int         REG_COUNT     = 4;

  // Inter-byte gap limit in sys_clk cycles: byte times * 10 bits * cycles per bit.
  function automatic int timeout_cyc(input int timeout_bytes, input int clk_freq,
                                     input int uart_bps);
    return timeout_bytes * 10 * (clk_freq / uart_bps);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and fires a
// one-cycle expire when the count reaches LIMIT-1 without a clear.
module uart_gap_timer #(
  parameter int LIMIT = 200
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int             CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  // A clear in the same cycle suppresses expiry, so an arriving byte wins.
  assign expire = en && !clr && (cnt == LAST);

  // Counter clears when disabled, on clear, and on expiry; otherwise it
  // increments and holds at LAST rather than wrapping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (!en || clr || expire) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses HEAD/ADDR/DATA/SUM frames from a UART byte stream and writes
// accepted DATA into a four-entry configuration register bank.
// Byte input handshake: pi_data is valid only in the single cycle pi_flag
// is high; there is no back-pressure, every strobed byte is consumed.
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter int         UART_BPS      = 9600,
  parameter int         CLK_FREQ      = 50_000_000,
  parameter logic [7:0] HEAD_BYTE     = HEAD_BYTE_DEF,
  parameter int         TIMEOUT_BYTES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [7:0] reg_out0,
  output logic [7:0] reg_out1,
  output logic [7:0] reg_out2,
  output logic [7:0] reg_out3,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic       frame_ok,
  output logic       frame_err,
  output state_t     fsm_state
);

  localparam int TIMEOUT_CYC = timeout_cyc(TIMEOUT_BYTES, CLK_FREQ, UART_BPS);

  state_t     state_q, state_d;
  logic [7:0] addr_q, data_q;
  logic [7:0] regs [REG_COUNT];
  logic [7:0] sum;
  logic       latch_addr, latch_data, do_wr, do_err;
  logic       gap_expire;

  assign sum       = addr_q + data_q;
  assign fsm_state = state_q;
  assign reg_out0  = regs[0];
  assign reg_out1  = regs[1];
  assign reg_out2  = regs[2];
  assign reg_out3  = regs[3];

  uart_gap_timer #(.LIMIT(TIMEOUT_CYC)) u_gap_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (state_q != IDLE),
    .clr       (pi_flag),
    .expire    (gap_expire)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state decode and frame check; a byte always takes priority over expiry.
  always_comb begin
    state_d    = state_q;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    do_wr      = 1'b0;
    do_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pi_flag && pi_data == HEAD_BYTE) state_d = GET_ADDR;
      end
      GET_ADDR: begin
        if (pi_flag) begin
          latch_addr = 1'b1;
          state_d    = GET_DATA;
        end else if (gap_expire) begin
          do_err  = 1'b1;
          state_d = IDLE;
        end
      end
      GET_DATA: begin
        if (pi_flag) begin
          latch_data = 1'b1;
          state_d    = GET_SUM;
        end else if (gap_expire) begin
          do_err  = 1'b1;
          state_d = IDLE;
        end
      end
      GET_SUM: begin
        if (pi_flag) begin
          state_d = IDLE;
          if (pi_data == sum && addr_q[7:2] == 6'd0) do_wr  = 1'b1;
          else                                       do_err = 1'b1;
        end else if (gap_expire) begin
          do_err  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Field latches, register bank write and registered result pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q    <= '0;
      data_q    <= '0;
      wr_addr   <= '0;
      wr_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      wr_en     <= do_wr;
      frame_ok  <= do_wr;
      frame_err <= do_err;
      if (latch_addr) addr_q <= pi_data;
      if (latch_data) data_q <= pi_data;
      if (do_wr) begin
        regs[addr_q[1:0]] <= data_q;
        wr_addr           <= addr_q[1:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl with a short gap limit (200 cycles).
module tb_uart_frame_ctrl;
  import uart_frame_ctrl_pkg::*;

  localparam int TC = 200; // 2 bytes * 10 bits * (1000 / 100)

  // Clock and reset.
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [7:0] pi_data = 8'h00;
  logic       pi_flag = 1'b0;
  logic [7:0] reg_out0, reg_out1, reg_out2, reg_out3;
  logic       wr_en, frame_ok, frame_err;
  logic [1:0] wr_addr;
  state_t     fsm_state;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int ok_cnt = 0;
  int both_cnt = 0;
  int err_mark, ok_mark;
  logic early_err;

  uart_frame_ctrl #(
    .UART_BPS(100), .CLK_FREQ(1000), .HEAD_BYTE(8'hA5), .TIMEOUT_BYTES(2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pi_data   (pi_data),
    .pi_flag   (pi_flag),
    .reg_out0  (reg_out0),
    .reg_out1  (reg_out1),
    .reg_out2  (reg_out2),
    .reg_out3  (reg_out3),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .fsm_state (fsm_state)
  );

  // Pulse tally sampled away from the active edge.
  always @(negedge sys_clk) begin
    if (frame_err) err_cnt++;
    if (frame_ok) ok_cnt++;
    if (frame_ok && frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one-cycle strobe; returns #1 after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge sys_clk); #1;
    pi_data = b;
    pi_flag = 1'b1;
    @(posedge sys_clk); #1;
    pi_flag = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] s);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(s);
  endtask

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] r3);
    chk({tag, "_r0"}, 32'(reg_out0), 32'(r0));
    chk({tag, "_r1"}, 32'(reg_out1), 32'(r1));
    chk({tag, "_r2"}, 32'(reg_out2), 32'(r2));
    chk({tag, "_r3"}, 32'(reg_out3), 32'(r3));
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge sys_clk);
    #1;
    chk_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_ok", 32'(frame_ok), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    sys_rst_n = 1'b1;
    step();

    // Good write to register 2.
    send_frame(8'h02, 8'h3C, 8'h3E);
    chk("good_wr_en", 32'(wr_en), 32'd1);
    chk("good_ok", 32'(frame_ok), 32'd1);
    chk("good_err", 32'(frame_err), 32'd0);
    chk("good_wr_addr", 32'(wr_addr), 32'd2);
    chk_regs("good", 8'h00, 8'h00, 8'h3C, 8'h00);
    step();
    chk("good_wr_en_1cyc", 32'(wr_en), 32'd0);
    chk("good_ok_1cyc", 32'(frame_ok), 32'd0);

    // Seed register 1 so the bad-sum case has a prior value to keep.
    send_frame(8'h01, 8'h55, 8'h56);
    chk("seed_ok", 32'(frame_ok), 32'd1);
    chk_regs("seed", 8'h00, 8'h55, 8'h3C, 8'h00);

    // Bad sum.
    send_frame(8'h01, 8'h10, 8'h12);
    chk("badsum_err", 32'(frame_err), 32'd1);
    chk("badsum_wr_en", 32'(wr_en), 32'd0);
    chk("badsum_ok", 32'(frame_ok), 32'd0);
    chk("badsum_wr_addr", 32'(wr_addr), 32'd1);
    chk_regs("badsum", 8'h00, 8'h55, 8'h3C, 8'h00);
    step();
    chk("badsum_err_1cyc", 32'(frame_err), 32'd0);

    // Bad address (correct sum, ADDR[7:2] nonzero).
    send_frame(8'h05, 8'h11, 8'h16);
    chk("badaddr_err", 32'(frame_err), 32'd1);
    chk("badaddr_wr_en", 32'(wr_en), 32'd0);
    chk("badaddr_ok", 32'(frame_ok), 32'd0);
    chk_regs("badaddr", 8'h00, 8'h55, 8'h3C, 8'h00);

    // Noise in IDLE.
    step();
    err_mark = err_cnt;
    ok_mark = ok_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (5) step();
    chk("noise_err", 32'(err_cnt - err_mark), 32'd0);
    chk("noise_ok", 32'(ok_cnt - ok_mark), 32'd0);
    chk("noise_state", 32'(fsm_state), 32'(IDLE));

    // Timeout: frame_err exactly TC cycles after the ADDR strobe.
    send_byte(8'hA5);
    send_byte(8'h01);
    early_err = 1'b0;
    for (int k = 1; k < TC; k++) begin
      step();
      if (frame_err) early_err = 1'b1;
    end
    chk("tmo_no_early_err", 32'(early_err), 32'd0);
    step();
    chk("tmo_err", 32'(frame_err), 32'd1);
    chk("tmo_state", 32'(fsm_state), 32'(IDLE));
    step();
    chk("tmo_err_1cyc", 32'(frame_err), 32'd0);
    send_frame(8'h01, 8'hAA, 8'hAB);
    chk("post_tmo_ok", 32'(frame_ok), 32'd1);
    chk_regs("post_tmo", 8'h00, 8'hAA, 8'h3C, 8'h00);

    // 8-bit sum wrap.
    send_frame(8'h03, 8'hFF, 8'h02);
    chk("wrap_ok", 32'(frame_ok), 32'd1);
    chk("wrap_wr_addr", 32'(wr_addr), 32'd3);
    chk_regs("wrap", 8'h00, 8'hAA, 8'h3C, 8'hFF);

    // Byte strobed on the exact expiry cycle wins.
    send_byte(8'hA5);
    send_byte(8'h00);
    err_mark = err_cnt;
    repeat (TC - 1) @(posedge sys_clk);
    #1;
    pi_data = 8'h12;
    pi_flag = 1'b1;
    @(posedge sys_clk); #1;
    pi_flag = 1'b0;
    chk("edge_no_err", 32'(frame_err), 32'd0);
    chk("edge_err_cnt", 32'(err_cnt - err_mark), 32'd0);
    chk("edge_state", 32'(fsm_state), 32'(GET_SUM));
    send_byte(8'h12);
    chk("edge_ok", 32'(frame_ok), 32'd1);
    chk_regs("edge", 8'h12, 8'hAA, 8'h3C, 8'hFF);

    // Reset mid-frame.
    step();
    send_byte(8'hA5);
    send_byte(8'h00);
    err_mark = err_cnt;
    ok_mark = ok_cnt;
    sys_rst_n = 1'b0;
    #1;
    chk_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_state", 32'(fsm_state), 32'(IDLE));
    step();
    sys_rst_n = 1'b1;
    send_byte(8'h00);
    send_byte(8'h7F);
    send_byte(8'h7F);
    repeat (3) step();
    chk("midrst_err_cnt", 32'(err_cnt - err_mark), 32'd0);
    chk("midrst_ok_cnt", 32'(ok_cnt - ok_mark), 32'd0);
    chk("midrst_no_head_r0", 32'(reg_out0), 32'h00);
    send_frame(8'h00, 8'h7F, 8'h7F);
    chk("midrst_ok", 32'(frame_ok), 32'd1);
    chk_regs("midrst_wr", 8'h7F, 8'h00, 8'h00, 8'h00);
    step();

    chk("ok_err_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameter UART_BPS, default 9600, serial bit rate in bits per second.
REQ-002 Parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-003 Parameter HEAD_BYTE, default 8'hA5, frame start byte.
REQ-004 Parameter TIMEOUT_BYTES, default 2, inter-byte gap tolerance in byte times.
REQ-005 sys_clk  input  1  single clock, rising edge.
REQ-006 sys_rst_n  input  1  asynchronous active-low reset.
REQ-007 pi_data  input  8  received byte, valid when pi_flag=1.
REQ-008 pi_flag  input  1  one-cycle byte-valid strobe from the UART receiver.
REQ-009 reg_out0..reg_out3  output  8 each  configuration register bank contents.
REQ-010 wr_en  output  1  one-cycle pulse on a committed register write.
REQ-011 wr_addr  output  2  index of the register written; held until the next write.
REQ-012 frame_ok  output  1  one-cycle pulse on an accepted frame.
REQ-013 frame_err  output  1  one-cycle pulse on a rejected or timed-out frame.

Function
REQ-014 Frame format SHALL be HEAD, ADDR, DATA, SUM, with SUM = (ADDR + DATA) mod 256.
REQ-015 FSM states SHALL be IDLE, GET_ADDR, GET_DATA, GET_SUM.
REQ-016 IDLE + pi_flag + pi_data==HEAD_BYTE -> GET_ADDR.
REQ-017 In IDLE, any other byte SHALL be discarded silently: no error pulse.
REQ-018 GET_ADDR + pi_flag -> latch ADDR, then GET_DATA.
REQ-019 GET_DATA + pi_flag -> latch DATA, then GET_SUM.
REQ-020 GET_SUM + pi_flag -> IDLE, with the frame check below applied.
REQ-021 Check: SUM correct and ADDR[7:2]==0 -> accept.
  - Write DATA to reg_out[ADDR[1:0]].
  - wr_addr <= ADDR[1:0].
  - Pulse wr_en and frame_ok.
REQ-022 Check: wrong SUM, or ADDR[7:2]!=0 -> pulse frame_err only; no register changes.
REQ-023 Latency: wr_en, frame_ok, frame_err and the reg_out update SHALL appear on the cycle after the pi_flag cycle carrying SUM.
REQ-024 The reg_out update and wr_en SHALL occur on the same edge.
REQ-025 A HEAD_BYTE value received in GET_ADDR, GET_DATA or GET_SUM SHALL be treated as ordinary data (no resync).
REQ-026 Timeout limit: TIMEOUT_CYC = TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS) cycles.
REQ-027 Timeout counter:
  - Runs in any state other than IDLE.
  - Clears on every pi_flag and on entry to IDLE.
REQ-028 Counter reaching TIMEOUT_CYC - 1 without pi_flag -> pulse frame_err, go to IDLE, clear the counter.
REQ-029 pi_flag coinciding with timeout expiry -> the byte wins: no timeout, normal transition.
REQ-030 Counter width SHALL be sufficient for TIMEOUT_CYC.
REQ-031 Counter SHALL saturate, never wrap.
REQ-032 frame_ok and frame_err SHALL never be asserted in the same cycle.
REQ-033 Output pulses SHALL be exactly one cycle wide.

Reset
REQ-034 sys_rst_n low SHALL asynchronously force:
  - FSM to IDLE.
  - Timeout counter, latched ADDR/DATA and wr_addr to 0.
  - reg_out0..3 to 8'h00.
  - wr_en, frame_ok, frame_err to 0.
REQ-035 Reset during a partial frame SHALL discard it with no error pulse.
REQ-036 After deassertion, the first accepted byte SHALL be a HEAD_BYTE.

Structure
REQ-037 A shared package SHALL hold:
  - The FSM state encoding.
  - HEAD_BYTE default.
  - Register count 4.
  - The TIMEOUT_CYC derivation function.
REQ-038 The timeout counter SHALL be one sub-module, uart_gap_timer, with these ports:
  - Clock and reset.
  - Enable input.
  - Clear input.
  - One-cycle expire output.
REQ-039 The FSM, frame check and register bank SHALL stay in uart_frame_ctrl.

Verification
REQ-040 Good write: bytes A5,02,3C,3E -> one cycle after 3E strobe, wr_en=1, frame_ok=1, wr_addr=2, reg_out2=8'h3C; other registers unchanged.
REQ-041 Bad sum: bytes A5,01,10,12 -> frame_err pulse; wr_en=0; reg_out1 keeps its prior value.
REQ-042 Bad addr: bytes A5,05,11,16 -> frame_err pulse; no register changes.
REQ-043 Noise plus timeout:
  - Bytes 00,FF in IDLE -> no pulses.
  - Then A5,01 and silence -> frame_err exactly TIMEOUT_CYC cycles after the 01 strobe.
  - Then A5,01,AA,AB -> reg_out1=8'hAA.
REQ-044 Boundary: 8-bit sum wrap, bytes A5,03,FF,02 -> reg_out3=8'hFF, frame_ok.
REQ-045 Boundary: byte strobe on the exact timeout-expiry cycle -> no frame_err; frame continues.
REQ-046 Reset mid-frame: assert sys_rst_n after A5,00 -> all outputs 0, no pulses; then A5,00,7F,7F -> reg_out0=8'h7F.
